// File: rtl/dcache_pkg.sv
// Shared types and field layout for the set-associative write-back L1 data cache.
// State encoding, default address split and tag-entry bit offsets.
package dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WB,
    S_REFILL,
    S_REFILLOK
  } state_t;

  localparam int OFF_DEF = 5;
  localparam int IDX_DEF = 5;
  localparam int TAG_DEF = 22;

  // entry = {valid, dirty, tag}; offsets count up from the top tag bit
  localparam int E_DIRTY = 0;
  localparam int E_VALID = 1;

endpackage

// File: rtl/dcache_way_sram.sv
// One cache way: tag entry and line arrays, synchronous write, asynchronous read.
// Only valid/dirty bits are reset; tags and data keep stale contents.
module dcache_way_sram
  import dcache_pkg::*;
#(
  parameter int TAG    = TAG_DEF,
  parameter int IDX    = IDX_DEF,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX-1:0]    idx,
  input  logic              we,
  input  logic [TAG+1:0]    wr_entry,
  input  logic [LINE_W-1:0] wr_line,
  output logic [TAG+1:0]    entry,
  output logic [LINE_W-1:0] line
);

  localparam int SETS = 1 << IDX;

  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic [TAG-1:0]    tags [SETS];
  logic [LINE_W-1:0] data [SETS];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[idx] <= wr_entry[TAG+E_VALID];
      dirty[idx] <= wr_entry[TAG+E_DIRTY];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      tags[idx] <= wr_entry[TAG-1:0];
      data[idx] <= wr_line;
    end
  end

  always_comb begin
    entry = {2'b00, tags[idx]};
    entry[TAG+E_VALID] = valid[idx];
    entry[TAG+E_DIRTY] = dirty[idx];
  end

  assign line = data[idx];

endmodule

// File: rtl/dcache_sa_wb.sv
// Set-associative write-back write-allocate L1 data cache.
// Hits answer combinationally; misses stall through write-back and refill.
module dcache_sa_wb
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o
);

  localparam int OFF  = $clog2(LINE_W / 8);
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = ADDR_W - OFF - IDX;
  localparam int WSEL = $clog2(LINE_W / WORD_W);
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t            state;
  logic [IDX-1:0]    idx_q;
  logic [TAG-1:0]    tag_q;
  logic [WB-1:0]     vic_q;
  logic [WB-1:0]     vic;
  logic [WB-1:0]     hit_way;
  logic [SETS-1:0]   lru;

  logic              req;
  logic [TAG-1:0]    p_tag;
  logic [IDX-1:0]    p_idx;
  logic [WSEL-1:0]   wsel;
  logic [IDX-1:0]    idx;
  logic              hit;
  logic              store_hit;
  logic              refill_wr;
  logic [WAYS-1:0]   hit_w;
  logic [WAYS-1:0]   we;
  logic [TAG+1:0]    ent  [WAYS];
  logic [LINE_W-1:0] line [WAYS];
  logic [TAG+1:0]    wr_entry;
  logic [LINE_W-1:0] wr_line;
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] merged;
  logic [TAG+1:0]    vic_ent;
  logic [LINE_W-1:0] vic_line;
  logic              unused_bits;

  assign req   = p1_MemRead_i | p1_MemWrite_i;
  assign p_tag = p1_addr_i[ADDR_W-1 -: TAG];
  assign p_idx = p1_addr_i[OFF +: IDX];
  assign wsel  = p1_addr_i[2 +: WSEL];
  assign unused_bits = ^p1_addr_i[1:0];

  // While a miss is in flight the latched index owns the arrays
  assign idx = (state == S_IDLE) ? p_idx : idx_q;

  assign refill_wr = (state == S_REFILL) & mem_ack_i;
  assign store_hit = (state == S_IDLE) & p1_MemWrite_i & hit;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way_sram #(
      .TAG    (TAG),
      .IDX    (IDX),
      .LINE_W (LINE_W)
    ) u_way (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .idx      (idx),
      .we       (we[w]),
      .wr_entry (wr_entry),
      .wr_line  (wr_line),
      .entry    (ent[w]),
      .line     (line[w])
    );
    assign hit_w[w] = req & ent[w][TAG+E_VALID]
                    & (ent[w][TAG-1:0] == p_tag);
    assign we[w] = refill_wr ? (vic_q == WB'(w))
                 : (store_hit & (hit_way == WB'(w)));
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_w[w]) hit_way = WB'(w);
  end

  assign hit      = |hit_w;
  assign hit_line = line[hit_way];

  always_comb begin
    merged = hit_line;
    merged[wsel*WORD_W +: WORD_W] = p1_data_i;
  end

  always_comb begin
    wr_entry = '0;
    wr_entry[TAG+E_VALID] = 1'b1;
    wr_entry[TAG+E_DIRTY] = ~refill_wr;
    wr_entry[TAG-1:0]     = refill_wr ? tag_q : p_tag;
    wr_line = refill_wr ? mem_data_i : merged;
  end

  assign p1_data_o  = hit ? hit_line[wsel*WORD_W +: WORD_W] : '0;
  assign p1_stall_o = req & (~hit | (state != S_IDLE));

  // Lowest invalid way wins; otherwise the LRU way is evicted
  always_comb begin
    vic = (WAYS > 1) ? WB'(lru[idx_q]) : '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!ent[w][TAG+E_VALID]) vic = WB'(w);
  end

  assign vic_ent  = ent[vic];
  assign vic_line = line[vic];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      lru <= '0;
    else if (state == S_IDLE && hit)
      lru[p_idx] <= (hit_way == '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= S_IDLE;
      idx_q        <= '0;
      tag_q        <= '0;
      vic_q        <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req && !hit) begin
            state <= S_MISS;
            idx_q <= p_idx;
            tag_q <= p_tag;
          end
        end
        S_MISS: begin
          vic_q        <= vic;
          mem_enable_o <= 1'b1;
          if (vic_ent[TAG+E_VALID] && vic_ent[TAG+E_DIRTY]) begin
            state       <= S_WB;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {vic_ent[TAG-1:0], idx_q, {OFF{1'b0}}};
            mem_data_o  <= vic_line;
          end else begin
            state       <= S_REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag_q, idx_q, {OFF{1'b0}}};
          end
        end
        S_WB: begin
          if (mem_ack_i) begin
            state       <= S_REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag_q, idx_q, {OFF{1'b0}}};
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            state        <= S_REFILLOK;
            mem_enable_o <= 1'b0;
          end
        end
        S_REFILLOK: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_sa_wb.sv
// Randomised bench for dcache_sa_wb against a set/way/LRU cache model
// and a line-addressed memory model with configurable ack delay.
module tb_dcache_sa_wb;

  typedef struct {
    bit           w;
    logic [31:0]  a;
    logic [255:0] d;
  } tx_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] mem_data_i;
  logic         mem_ack;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  p1_data;
  logic [31:0]  p1_addr;
  logic         p1_MemRead;
  logic         p1_MemWrite;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;

  dcache_sa_wb dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .p1_data_i     (p1_data),
    .p1_addr_i     (p1_addr),
    .p1_MemRead_i  (p1_MemRead),
    .p1_MemWrite_i (p1_MemWrite),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cache model: per set, two ways and the way to evict next
  bit           m_v   [32][2];
  bit           m_d   [32][2];
  logic [21:0]  m_t   [32][2];
  logic [255:0] m_l   [32][2];
  int           m_lru [32];

  // Memory model: written lines stored, untouched lines derived from address
  logic [255:0] mem_st [logic [31:0]];

  function automatic logic [255:0] memline(logic [31:0] a);
    logic [255:0] l;
    if (mem_st.exists(a)) return mem_st[a];
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = (a * 32'h0001_0003) ^ (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    return l;
  endfunction

  function automatic logic [31:0] getw(logic [255:0] l, int ws);
    return l[ws*32 +: 32];
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 32; s++) begin
      m_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 0;
        m_d[s][w] = 0;
      end
    end
  endfunction

  function automatic void apply_hit(int s, int w, bit wr, int ws,
                                    logic [31:0] d);
    if (wr) begin
      m_l[s][w][ws*32 +: 32] = d;
      m_d[s][w] = 1;
    end
    m_lru[s] = 1 - w;
  endfunction

  // Memory responder: holds-check every busy cycle, acks after delay
  int           delay   = 3;
  bit           busy    = 0;
  bit           spur    = 0;
  int           cnt     = 0;
  int           ack_age = 100;
  bit           cur_w;
  logic [31:0]  cur_a;
  logic [255:0] cur_d;
  logic [31:0]  rnd;
  tx_t          txq [$];
  tx_t          txlog [$];
  tx_t          tt;

  always @(negedge clk) begin
    if (!rst) begin
      busy    = 0;
      mem_ack = 0;
    end else begin
      mem_ack = 0;
      ack_age++;
      if (busy) begin
        chk(mem_enable_o && mem_addr_o == cur_a && mem_write_o == cur_w &&
            (!cur_w || mem_data_o == cur_d), "mem_hold",
            {mem_enable_o, mem_write_o, mem_addr_o},
            {1'b1, cur_w, cur_a});
        cnt++;
        if (cnt >= delay) begin
          mem_ack = 1;
          ack_age = 0;
          busy    = 0;
          tt.w = cur_w;
          tt.a = cur_a;
          tt.d = cur_d;
          txq.push_back(tt);
          if (cur_w) mem_st[cur_a] = cur_d;
          else mem_data_i = memline(cur_a);
        end
      end else if (mem_enable_o) begin
        busy  = 1;
        cnt   = 0;
        cur_w = mem_write_o;
        cur_a = mem_addr_o;
        cur_d = mem_data_o;
      end else if (spur) begin
        rnd = $urandom();
        mem_ack    = 1;
        mem_data_i = {8{rnd}};
        spur       = 0;
      end
    end
  end

  bit          first_stall;
  logic [31:0] last_data;

  task automatic access(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit drop);
    int s, ws, hw, v;
    logic [21:0] tg;
    tx_t e;
    tx_t exq [$];
    bit done;
    s  = int'(a[9:5]);
    ws = int'(a[4:2]);
    tg = a[31:10];
    @(negedge clk);
    #1;
    txq.delete();
    p1_MemRead  = !wr;
    p1_MemWrite = wr;
    p1_addr     = a;
    p1_data     = d;
    #1;
    first_stall = p1_stall_o;
    hw = -1;
    for (int w = 1; w >= 0; w--)
      if (m_v[s][w] && m_t[s][w] == tg) hw = w;
    if (hw >= 0) begin
      chk(p1_stall_o == 0, "hit_stall", p1_stall_o, 0);
      chk(p1_data_o == getw(m_l[s][hw], ws), "hit_data",
          p1_data_o, getw(m_l[s][hw], ws));
      chk(!mem_enable_o, "hit_no_mem", mem_enable_o, 0);
      last_data = p1_data_o;
      apply_hit(s, hw, wr, ws, d);
      txlog = txq;
      return;
    end
    chk(p1_stall_o == 1, "miss_stall", p1_stall_o, 1);
    chk(p1_data_o == 0, "miss_data_zero", p1_data_o, 0);
    v = !m_v[s][0] ? 0 : (!m_v[s][1] ? 1 : m_lru[s]);
    if (m_v[s][v] && m_d[s][v]) begin
      e.w = 1;
      e.a = {m_t[s][v], 5'(s), 5'b0};
      e.d = m_l[s][v];
      exq.push_back(e);
    end
    e.w = 0;
    e.a = {tg, 5'(s), 5'b0};
    e.d = '0;
    exq.push_back(e);
    done = 0;
    if (drop) begin
      @(negedge clk);
      #1;
      p1_MemRead  = 0;
      p1_MemWrite = 0;
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk);
        #2;
        done = (txq.size() == exq.size()) && ack_age >= 2;
      end
    end else begin
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk);
        #2;
        done = !p1_stall_o;
      end
    end
    if (!done) begin
      chk(0, "miss_timeout", txq.size(), exq.size());
      txlog = txq;
      return;
    end
    chk(txq.size() == exq.size(), "mem_req_count", txq.size(), exq.size());
    for (int i = 0; i < exq.size() && i < txq.size(); i++)
      chk(txq[i].w == exq[i].w && txq[i].a == exq[i].a &&
          (!exq[i].w || txq[i].d == exq[i].d), "mem_req",
          {txq[i].w, txq[i].a, txq[i].d[31:0]},
          {exq[i].w, exq[i].a, exq[i].d[31:0]});
    m_v[s][v] = 1;
    m_d[s][v] = 0;
    m_t[s][v] = tg;
    m_l[s][v] = memline(e.a);
    if (!drop) begin
      chk(ack_age == 2, "refill_latency", ack_age, 2);
      chk(p1_data_o == getw(m_l[s][v], ws), "fill_data",
          p1_data_o, getw(m_l[s][v], ws));
      last_data = p1_data_o;
      apply_hit(s, v, wr, ws, d);
    end
    txlog = txq;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 0;
    p1_MemRead  = 0;
    p1_MemWrite = 0;
    #1;
    chk(mem_enable_o == 0, "rst_enable", mem_enable_o, 0);
    chk(mem_write_o == 0, "rst_write", mem_write_o, 0);
    chk(mem_addr_o == 0, "rst_addr", mem_addr_o, 0);
    chk(mem_data_o == 0, "rst_data", mem_data_o, 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1;
    model_clear();
    txq.delete();
  endtask

  initial begin
    bit done;
    logic [31:0] a;
    rst = 0;
    mem_ack = 0;
    mem_data_i = '0;
    p1_MemRead = 0;
    p1_MemWrite = 0;
    p1_addr = '0;
    p1_data = '0;
    do_reset();

    access(0, 32'h0000_0404, 0, 0);
    chk(first_stall == 1, "t1_stall", first_stall, 1);
    chk(txlog.size() == 1 && txlog[0].a == 32'h400 && txlog[0].w == 0,
        "t1_refill_req", txlog.size() > 0 ? txlog[0].a : 0, 32'h400);

    access(1, 32'h0000_0400, 32'hDEAD_BEEF, 0);
    chk(first_stall == 0, "t2_store_hit", first_stall, 0);
    access(0, 32'h0000_0400, 0, 0);
    chk(last_data == 32'hDEAD_BEEF, "t2_reload", last_data, 32'hDEAD_BEEF);

    access(0, 32'h0000_0800, 0, 0);
    chk(txlog.size() == 1 && txlog[0].a == 32'h800 && txlog[0].w == 0,
        "t3_fill_way1", txlog.size(), 1);
    access(0, 32'h0000_0C00, 0, 0);
    chk(txlog.size() == 2 && txlog[0].w == 1 && txlog[0].a == 32'h400 &&
        txlog[0].d[31:0] == 32'hDEAD_BEEF && txlog[1].a == 32'hC00,
        "t3_writeback", txlog.size() > 0 ? txlog[0].d[31:0] : 0,
        32'hDEAD_BEEF);

    do_reset();
    access(0, 32'h0000_0400, 0, 0);
    access(0, 32'h0000_0800, 0, 0);
    access(0, 32'h0000_0400, 0, 0);
    access(0, 32'h0000_0C00, 0, 0);
    chk(txlog.size() == 1 && txlog[0].a == 32'hC00 && txlog[0].w == 0,
        "t4_evict_clean", txlog.size(), 1);
    access(0, 32'h0000_0400, 0, 0);
    chk(first_stall == 0, "t4_400_hit", first_stall, 0);
    access(0, 32'h0000_0800, 0, 0);
    chk(first_stall == 1, "t4_800_miss", first_stall, 1);

    delay = 10;
    access(1, 32'h0000_1008, 32'h1234_5678, 0);
    spur = 1;
    repeat (3) @(negedge clk);
    #2;
    chk(mem_enable_o == 0, "t5_spurious_ack", mem_enable_o, 0);
    access(0, 32'h0000_1008, 0, 0);
    chk(first_stall == 0 && last_data == 32'h1234_5678, "t5_hit_after",
        last_data, 32'h1234_5678);

    access(0, 32'h0000_0400, 0, 0);
    @(negedge clk);
    #1;
    p1_MemRead = 1;
    p1_MemWrite = 0;
    p1_addr = 32'h0000_2000;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      #2;
      done = mem_enable_o && !mem_write_o;
    end
    chk(done, "t6_refill_seen", done, 1);
    repeat (3) @(negedge clk);
    #1;
    rst = 0;
    #1;
    chk(mem_enable_o == 0, "t6_async_reset", mem_enable_o, 0);
    p1_MemRead = 0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    rst = 1;
    txq.delete();
    delay = 3;
    access(0, 32'h0000_0400, 0, 0);
    chk(first_stall == 1, "t6_400_miss", first_stall, 1);

    access(1, 32'h0000_0464, 32'hA5A5_0001, 1);
    access(0, 32'h0000_0464, 0, 0);
    chk(first_stall == 0, "drop_filled", first_stall, 0);

    for (int k = 0; k < 300; k++) begin
      delay = $urandom_range(1, 5);
      a = {22'($urandom_range(1, 6)), 5'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      access(1'($urandom_range(0, 1)), a, $urandom(),
             $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    #1;
    p1_MemRead = 0;
    p1_MemWrite = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
